// File: rtl/wbaq_pkg.sv
// Shared types and constants for the write-back address queue (WBAQ).
package wbaq_pkg;

  localparam int LINE_BYTES = 16;

  // Store size encodings.
  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;
  localparam logic [1:0] SZ_8B = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [6:0]  ptcid;
  } entry_t;

  // Byte-lane mask of a store before it is shifted to its line offset.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_1B:   return 8'h01;
      SZ_2B:   return 8'h03;
      SZ_4B:   return 8'h0F;
      SZ_8B:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Number of bytes written by a store of the given size.
  function automatic logic [4:0] size_bytes(input logic [1:0] size);
    return 5'd1 << size;
  endfunction

  // True when the store runs past the end of its 16-byte line.
  function automatic logic is_split(input entry_t e);
    return ({1'b0, e.addr[3:0]} + size_bytes(e.size)) > 5'(LINE_BYTES);
  endfunction

endpackage

// File: rtl/wbaq_line_align.sv
// Positions one queue entry onto a D$ line access. hi=0 selects the access
// to the store's own line, hi=1 the spill-over into the following line.
module wbaq_line_align
  import wbaq_pkg::*;
(
  input  entry_t         ent,
  input  logic           hi,
  output logic [27:0]    line_addr,
  output logic [15:0]    be,
  output logic [127:0]   wdata,
  output logic           split
);

  logic [3:0]   off;
  logic [31:0]  be_wide;
  logic [255:0] data_wide;
  logic [6:0]   ptcid_unused;

  assign off          = ent.addr[3:0];
  assign ptcid_unused = ent.ptcid;

  // Shift into a two-line window: the lower line is the LO access, whatever
  // spills past byte 15 lands in the upper line and forms the HI access.
  assign be_wide   = {24'b0, size_mask(ent.size)} << off;
  assign data_wide = {192'b0, ent.data} << {off, 3'b000};

  assign split     = is_split(ent);
  assign line_addr = ent.addr[31:4] + {27'b0, hi};
  assign be        = hi ? be_wide[31:16] : be_wide[15:0];
  assign wdata     = hi ? data_wide[255:128] : data_wide[127:0];

endmodule

// File: rtl/wbaq_ctrl.sv
// Write-back address queue controller: buffers committed stores and drains
// them to the D$ one line access at a time, splitting line-crossing stores.
// Optional macro WBAQ_FWD_CHK_EN adds a combinational store-hit probe port.
module wbaq_ctrl
  import wbaq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [31:0]      enq_addr,
  input  logic [63:0]      enq_data,
  input  logic [1:0]       enq_size,
  input  logic [6:0]       enq_ptcid,
  output logic             wbaq_full,
  output logic             wbaq_empty,
  output logic [PTR_W:0]   wbaq_count,
  output logic             dc_req,
  output logic [27:0]      dc_line_addr,
  output logic [127:0]     dc_wdata,
  output logic [15:0]      dc_be,
  input  logic             dc_ack,
  output logic             ptc_rel_valid,
  output logic [6:0]       ptc_rel_id,
  input  logic             drain_req,
`ifdef WBAQ_FWD_CHK_EN
  input  logic             probe_valid,
  input  logic [27:0]      probe_line,
  output logic             probe_hit,
`endif
  output logic             drained
);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  state_t             state, state_next;
  logic               enq, pop, more;
  entry_t             head;
  logic [27:0]        al_line;
  logic [15:0]        al_be;
  logic [127:0]       al_wdata;
  logic               al_split;
  logic               drain_req_unused;

  // drain_req is only an observation hook; drained is reported regardless.
  assign drain_req_unused = drain_req;

  assign wbaq_full  = (count == (PTR_W+1)'(DEPTH));
  assign wbaq_empty = (count == '0);
  assign wbaq_count = count;
  assign enq        = enq_valid & ~wbaq_full;
  assign head       = mem[rd_ptr];
  // Entries remain after this pop if more than one was queued or one arrives now.
  assign more       = (count != (PTR_W+1)'(1)) | enq;

  // Store storage; written only at the free slot, so the head stays stable.
  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{addr: enq_addr, data: enq_data,
                              size: enq_size, ptcid: enq_ptcid};
  end

  // Pointers, occupancy and FSM state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_IDLE;
    end else begin
      state <= state_next;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state and pop decode.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: if (!wbaq_empty) state_next = ST_LO;
      ST_LO: begin
        if (dc_ack) begin
          if (al_split) begin
            state_next = ST_HI;
          end else begin
            pop        = 1'b1;
            state_next = more ? ST_LO : ST_IDLE;
          end
        end
      end
      ST_HI: begin
        if (dc_ack) begin
          pop        = 1'b1;
          state_next = more ? ST_LO : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Retirement pulse, one cycle after the accepting ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptc_rel_valid <= 1'b0;
      ptc_rel_id    <= '0;
    end else begin
      ptc_rel_valid <= pop;
      if (pop) ptc_rel_id <= head.ptcid;
    end
  end

  wbaq_line_align u_align (
    .ent       (head),
    .hi        (state == ST_HI),
    .line_addr (al_line),
    .be        (al_be),
    .wdata     (al_wdata),
    .split     (al_split)
  );

  // D$ request fields are forced to zero while idle so nothing stale leaks out.
  assign dc_req       = (state != ST_IDLE);
  assign dc_line_addr = dc_req ? al_line  : '0;
  assign dc_be        = dc_req ? al_be    : '0;
  assign dc_wdata     = dc_req ? al_wdata : '0;
  assign drained      = wbaq_empty & (state == ST_IDLE);

`ifdef WBAQ_FWD_CHK_EN
  logic [PTR_W-1:0] rel;

  // Compare the probed line against every occupied entry's line(s).
  always_comb begin
    probe_hit = 1'b0;
    rel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr;
      if ({1'b0, rel} < count) begin
        if ((mem[i].addr[31:4] == probe_line) ||
            (is_split(mem[i]) && (mem[i].addr[31:4] + 28'd1 == probe_line)))
          probe_hit = 1'b1;
      end
    end
    probe_hit = probe_hit & probe_valid;
  end
`endif

endmodule

// File: tb/tb_wbaq_ctrl.sv
// Directed self-checking bench for wbaq_ctrl.
module tb_wbaq_ctrl;

  logic          clk;
  logic          rst;
  logic          enq_valid;
  logic [31:0]   enq_addr;
  logic [63:0]   enq_data;
  logic [1:0]    enq_size;
  logic [6:0]    enq_ptcid;
  logic          wbaq_full;
  logic          wbaq_empty;
  logic [3:0]    wbaq_count;
  logic          dc_req;
  logic [27:0]   dc_line_addr;
  logic [127:0]  dc_wdata;
  logic [15:0]   dc_be;
  logic          dc_ack;
  logic          ptc_rel_valid;
  logic [6:0]    ptc_rel_id;
  logic          drain_req;
  logic          drained;

  int checks   = 0;
  int failures = 0;

  wbaq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_addr      (enq_addr),
    .enq_data      (enq_data),
    .enq_size      (enq_size),
    .enq_ptcid     (enq_ptcid),
    .wbaq_full     (wbaq_full),
    .wbaq_empty    (wbaq_empty),
    .wbaq_count    (wbaq_count),
    .dc_req        (dc_req),
    .dc_line_addr  (dc_line_addr),
    .dc_wdata      (dc_wdata),
    .dc_be         (dc_be),
    .dc_ack        (dc_ack),
    .ptc_rel_valid (ptc_rel_valid),
    .ptc_rel_id    (ptc_rel_id),
    .drain_req     (drain_req),
    .drained       (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [31:0] a, input logic [63:0] d,
                           input logic [1:0] s, input logic [6:0] id);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    enq_size  = s;
    enq_ptcid = id;
  endtask

  logic [15:0]  exp_be;
  logic [127:0] exp_wdata;
  logic [63:0]  st_data;
  int n_enq, n_acc, n_rel;
  logic ack;

  initial begin
    rst = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_size = '0;
    enq_ptcid = '0; dc_ack = 1'b0; drain_req = 1'b0;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_full",    wbaq_full,     0);
    check("rst_empty",   wbaq_empty,    1);
    check("rst_count",   wbaq_count,    0);
    check("rst_dc_req",  dc_req,        0);
    check("rst_line",    dc_line_addr,  0);
    check("rst_be",      dc_be,         0);
    check("rst_wdata",   dc_wdata,      0);
    check("rst_rel",     ptc_rel_valid, 0);
    check("rst_drained", drained,       1);
    rst = 1'b1;
    tick();

    // ---------------- aligned store
    drive_enq(32'h1000_0004, 64'hDEAD_BEEF, 2'd2, 7'd5);
    tick();
    enq_valid = 1'b0;
    check("al_count1",   wbaq_count, 1);
    check("al_latency",  dc_req,     0);
    check("al_drained0", drained,    0);
    tick();
    check("al_req",   dc_req,       1);
    check("al_line",  dc_line_addr, 28'h100_0000);
    check("al_be",    dc_be,        16'h00F0);
    check("al_wdata", dc_wdata,     128'h00000000_00000000_DEADBEEF_00000000);
    dc_ack = 1'b1;
    tick();
    dc_ack = 1'b0;
    check("al_rel",      ptc_rel_valid, 1);
    check("al_rel_id",   ptc_rel_id,    5);
    check("al_req_off",  dc_req,        0);
    check("al_drained1", drained,       1);
    tick();
    check("al_rel_pulse", ptc_rel_valid, 0);

    // ---------------- split store
    drive_enq(32'h2000_000C, 64'h1122_3344_5566_7788, 2'd3, 7'd9);
    tick();
    enq_valid = 1'b0;
    tick();
    check("sp_lo_line",  dc_line_addr, 28'h200_0000);
    check("sp_lo_be",    dc_be,        16'hF000);
    check("sp_lo_wdata", dc_wdata,     128'h55667788_00000000_00000000_00000000);
    dc_ack = 1'b1;
    tick();
    check("sp_hi_req",   dc_req,        1);
    check("sp_hi_line",  dc_line_addr,  28'h200_0001);
    check("sp_hi_be",    dc_be,         16'h000F);
    check("sp_hi_wdata", dc_wdata,      128'h11223344);
    check("sp_no_rel",   ptc_rel_valid, 0);
    tick();
    dc_ack = 1'b0;
    check("sp_rel",    ptc_rel_valid, 1);
    check("sp_rel_id", ptc_rel_id,    9);
    check("sp_idle",   dc_req,        0);
    tick();
    check("sp_rel_once", ptc_rel_valid, 0);

    // ---------------- backpressure and held request
    for (int i = 0; i < 8; i++) begin
      drive_enq(32'h3000_0000 + 32'(i << 4), 64'h1111_0000_0000_0000 + 64'(i), 2'd3, 7'(16 + i));
      tick();
    end
    check("bp_full",  wbaq_full,  1);
    check("bp_count", wbaq_count, 8);
    // 9th store presented and held while full
    drive_enq(32'h3000_0080, 64'h9999, 2'd3, 7'd99);
    for (int c = 0; c < 5; c++) begin
      check("hold_req",   dc_req,       1);
      check("hold_line",  dc_line_addr, 28'h300_0000);
      check("hold_be",    dc_be,        16'h00FF);
      check("hold_wdata", dc_wdata,     128'h1111_0000_0000_0000);
      check("hold_count", wbaq_count,   8);
      tick();
    end
    dc_ack = 1'b1;
    tick();
    enq_valid = 1'b0;
    check("bp_refused", wbaq_count,    7);
    check("bp_notfull", wbaq_full,     0);
    check("bp_rel_id",  ptc_rel_id,    16);
    check("bp_no_gap",  dc_req,        1);
    for (int k = 1; k < 8; k++) begin
      check("b2b_line", dc_line_addr, 28'h300_0000 + 28'(k));
      tick();
      check("b2b_rel",    ptc_rel_valid, 1);
      check("b2b_rel_id", ptc_rel_id,    7'(16 + k));
    end
    dc_ack = 1'b0;
    check("bp_drained_cnt", wbaq_count, 0);
    check("bp_req_off",     dc_req,     0);
    tick();
    check("bp_drained", drained, 1);

    // ---------------- wrap: 20 stores with random ack delays
    n_enq = 0; n_acc = 0; n_rel = 0;
    for (int cyc = 0; cyc < 600 && n_rel < 20; cyc++) begin
      if (ptc_rel_valid) begin
        check("wrap_rel_id", ptc_rel_id, 7'(40 + n_rel));
        n_rel++;
      end
      ack    = dc_req && ($urandom_range(0, 2) == 0);
      dc_ack = ack;
      if (ack) begin
        exp_be    = 16'h000F << ((n_acc % 4) * 4);
        st_data   = 64'hC0DE_0000 + 64'(n_acc);
        exp_wdata = {64'b0, st_data} << ((n_acc % 4) * 32);
        check("wrap_line",  dc_line_addr, 28'h400_0000 + 28'(n_acc));
        check("wrap_be",    dc_be,        exp_be);
        check("wrap_wdata", dc_wdata,     exp_wdata);
        n_acc++;
      end
      if (n_enq < 20 && !wbaq_full) begin
        drive_enq(32'h4000_0000 + 32'(n_enq << 4) + 32'((n_enq % 4) * 4),
                  64'hC0DE_0000 + 64'(n_enq), 2'd2, 7'(40 + n_enq));
        n_enq++;
      end else begin
        enq_valid = 1'b0;
      end
      tick();
    end
    dc_ack    = 1'b0;
    enq_valid = 1'b0;
    check("wrap_acc_total", n_acc, 20);
    check("wrap_rel_total", n_rel, 20);
    check("wrap_empty",     wbaq_empty, 1);

    // ---------------- reset while in HI
    drive_enq(32'h5000_000C, 64'hAAAA_BBBB_CCCC_DDDD, 2'd3, 7'd60);
    tick();
    drive_enq(32'h5000_0100, 64'h77, 2'd0, 7'd61);
    tick();
    enq_valid = 1'b0;
    dc_ack    = 1'b1;
    tick();
    dc_ack = 1'b0;
    check("rh_in_hi",  dc_line_addr, 28'h500_0001);
    check("rh_count2", wbaq_count,   2);
    #2;
    rst = 1'b0;
    #1;
    check("rh_req",     dc_req,     0);
    check("rh_count",   wbaq_count, 0);
    check("rh_empty",   wbaq_empty, 1);
    check("rh_drained", drained,    1);
    check("rh_be",      dc_be,      0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rh_post_req",   dc_req,        0);
    check("rh_post_rel",   ptc_rel_valid, 0);
    check("rh_post_count", wbaq_count,    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbaq_ctrl.md
Name: wbaq_ctrl

Overview:
Write-back address queue (WBAQ) controller. It sits between the writeback stage and the data cache, buffering committed memory stores (address, data, size, PTC id). It drains stores to the D$ one 16-byte line access at a time over a req/ack handshake, and splits line-crossing stores into two accesses. It produces the `wbaq_full` backpressure that writeback turns into its stall, and a drain indication for interrupt/serialisation.

Parameters:
- DEPTH, 8, number of queue entries (power of 2, ≥2)
- PTR_W, 3, log2(DEPTH)
- LINE_BYTES, 16, D$ line size in bytes (fixed 16; line address = addr[31:4])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enq_valid  in  1  writeback presents a store this cycle (`mem_ld` from writeback)
- enq_addr  in  32  byte address of store
- enq_data  in  64  store data, little-endian, LSB-justified
- enq_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
- enq_ptcid  in  7  instruction PTC id
- wbaq_full  out  1  queue holds DEPTH entries
- wbaq_empty  out  1  queue holds 0 entries
- wbaq_count  out  PTR_W+1  occupancy
- dc_req  out  1  D$ write request
- dc_line_addr  out  28  target line address
- dc_wdata  out  128  line-positioned write data
- dc_be  out  16  byte enables
- dc_ack  in  1  D$ accepts the current request this cycle
- ptc_rel_valid  out  1  one-cycle pulse when a store fully retires
- ptc_rel_id  out  7  PTC id of the retired store
- drain_req  in  1  interrupt/serialise request
- drained  out  1  queue empty and FSM idle

Behaviour:
- **Reset** (rst=0, asynchronous): rd/wr pointers=0, count=0, FSM=IDLE. Outputs: wbaq_full=0, wbaq_empty=1, wbaq_count=0, dc_req=0, dc_line_addr=0, dc_wdata=0, dc_be=0, ptc_rel_valid=0, ptc_rel_id=0, drained=1. Entries in flight mid-reset are discarded and dc_req drops immediately.
- **Enqueue:**
  - Writes at the rising edge when enq_valid=1 and wbaq_full=0.
  - enq_valid while full is ignored; writeback is already stalled by wbaq_full.
  - wbaq_full is registered state. Enqueue is refused when full, even if a pop occurs in the same cycle (no pass-through).
- **Count:** +1 on enqueue, −1 on pop, unchanged on simultaneous enqueue and pop. Pointers wrap modulo DEPTH.
- **Access geometry per head entry:**
  - off = addr[3:0]; bytes = 1<<size.
  - split = (off + bytes > 16).
- **FSM states: IDLE, LO, HI.**
  - IDLE: if count≠0 → LO next cycle. dc_req=0.
  - LO: dc_req=1, dc_line_addr=addr[31:4].
    - dc_be = ((1<<bytes)−1)<<off, truncated to 16 bits.
    - dc_wdata = {64'b0,data}<<(8·off), truncated to 128 bits.
    - On dc_ack: if split → HI; else pop.
  - HI: dc_req=1, dc_line_addr=addr[31:4]+1 (wraps modulo 2^28).
    - dc_be = ((1<<bytes)−1)>>(16−off).
    - dc_wdata = data>>(8·(16−off)), zero-extended.
    - On dc_ack: pop.
  - Pop: rd pointer advances and ptc_rel_valid pulses for one cycle, with ptc_rel_id = the popped entry's id.
  - After a pop, go to LO if entries remain (count−1+enq ≠ 0), else go to IDLE. Back-to-back stores therefore issue with no idle cycle.
- **Handshake:** while dc_req=1 and dc_ack=0, all dc_* outputs hold stable. dc_ack with dc_req=0 is ignored.
- **Latency:** a store enqueued at edge t into an empty, idle queue raises dc_req after edge t+1.
- **Drain:** drained = wbaq_empty & (FSM==IDLE). drain_req does not block enqueue; it only gates nothing internally and is an observable hook.

Optional Feature:
- **WBAQ_FWD_CHK_EN:** adds inputs `probe_valid` (1) and `probe_line` (28), and output `probe_hit` (1).
  - probe_hit = probe_valid & (any valid entry's LO line or, if split, HI line equals probe_line). Combinational, same cycle.
  - Lets the memory-read stage stall a load that hits a pending store.
- Without the macro: the ports are absent and no comparators are built.

Decomposition:
- Shared package `wbaq_pkg`: LINE_BYTES, size encoding constants (SZ_1B..SZ_8B), the FSM state enum, and the entry struct {addr[31:0], data[63:0], size[1:0], ptcid[6:0]}.
- One natural sub-module: `wbaq_line_align`, combinational. It takes entry + half select and produces line_addr, be, wdata and split.

Test Plan:
- **Aligned store:** enq addr=0x1000_0004, size=2, data=0xDEADBEEF, dc_ack one cycle after req.
  - → Single access: line=0x100_0000, be=0x00F0, wdata[63:32]=0xDEADBEEF.
  - → ptc_rel pulse; drained returns to 1.
- **Split store:** addr=0x2000_000C, size=3, data=0x1122334455667788.
  - → LO: line=0x200_0000, be=0xF000, wdata[127:96]=0x55667788.
  - → HI: line=0x200_0001, be=0x000F, wdata[31:0]=0x11223344.
  - → One ptc_rel only.
- **Backpressure:** 8 enqueues with dc_ack held 0.
  - → wbaq_full=1, count=8.
  - → A 9th enq_valid is ignored, even in the cycle the first ack pops.
- **Held request:** ack withheld for 5 cycles.
  - → dc_* stable throughout.
  - → Back-to-back entries issue with no IDLE gap after each ack.
- **Wrap:** 20 stores streamed with random ack delays.
  - → Pointers wrap; D$ write order and ptc_rel_id order match enqueue order.
- **Reset mid-HI:** drop rst while in the HI state.
  - → dc_req=0 immediately, count=0, wbaq_empty=1, drained=1.
